// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding, stall control, MD pending-write scoreboard and stall counter
module hazard_scoreboard_unit #(
    parameter int RA_W   = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  RsD,
    input  logic [RA_W-1:0]  RtD,
    input  logic             RegWriteD,
    input  logic [RA_W-1:0]  WriteRegD,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             MdOpD,
    input  logic [RA_W-1:0]  RsE,
    input  logic [RA_W-1:0]  RtE,
    input  logic [RA_W-1:0]  WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MdStartE,
    input  logic [RA_W-1:0]  WriteRegM,
    input  logic [RA_W-1:0]  WriteRegW,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             MdBusy,
    output logic             MdDone,
    output logic [RA_W-1:0]  MdDest,
    output logic [CNT_W-1:0] StallCount
);
    localparam int NR = 2**RA_W;

    logic [3:0]    mdcnt;
    logic [NR-1:0] sb, sb_next;
    logic          lwstall, branchstall, mdstall, stall, accept;
    logic          raw_a, raw_b, unused_jump;

    assign unused_jump = JumpD;

    // E- and D-stage forwarding selects; M beats W, register 0 never forwards
    always_comb begin
        ForwardAE = (RsE != '0 && RegWriteM && RsE == WriteRegM) ? 2'b10 :
                    (RsE != '0 && RegWriteW && RsE == WriteRegW) ? 2'b01 : 2'b00;
        ForwardBE = (RtE != '0 && RegWriteM && RtE == WriteRegM) ? 2'b10 :
                    (RtE != '0 && RegWriteW && RtE == WriteRegW) ? 2'b01 : 2'b00;
        ForwardAD = RsD != '0 && RegWriteM && RsD == WriteRegM;
        ForwardBD = RtD != '0 && RegWriteM && RtD == WriteRegM;
    end

    // Stall sources; a RAW on an MD result is released in the cycle it is written
    always_comb begin
        MdBusy      = mdcnt != 4'd0;
        MdDone      = mdcnt == 4'd1;
        lwstall     = MemtoRegE && RtE != '0 && (RsD == RtE || RtD == RtE);
        branchstall = BranchD &&
                      ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
        raw_a       = sb[RsD] && !(MdDone && RsD == MdDest);
        raw_b       = sb[RtD] && !(MdDone && RtD == MdDest);
        mdstall     = raw_a || raw_b || (MdOpD && mdcnt > 4'd1) ||
                      (RegWriteD && sb[WriteRegD] && !MdDone) ||
                      (MdStartE && RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD));
        stall       = lwstall || branchstall || mdstall;
        StallF      = stall;
        StallD      = stall;
        FlushE      = stall;
        accept      = MdStartE && mdcnt <= 4'd1 && !stall;
    end

    // Scoreboard next state: completion clears, accepted launch sets (set wins)
    always_comb begin
        sb_next = sb;
        if (MdDone) sb_next[MdDest] = 1'b0;
        if (accept && WriteRegE != '0) sb_next[WriteRegE] = 1'b1;
        sb_next[0] = 1'b0;
    end

    // MD latency counter, destination, scoreboard and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdcnt      <= '0;
            sb         <= '0;
            MdDest     <= '0;
            StallCount <= '0;
        end else begin
            mdcnt      <= accept ? 4'(MD_LAT) : (mdcnt != 4'd0 ? mdcnt - 4'd1 : 4'd0);
            sb         <= sb_next;
            if (accept) MdDest <= WriteRegE;
            if (stall && !(&StallCount)) StallCount <= StallCount + 1'b1;
        end
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation pipeline hazard controller for the 5-stage MiniMIPS core.
- Keeps the existing single-cycle functions: E-stage and D-stage forwarding, load-use stall, branch stall.
- Adds a pending-write scoreboard and a latency counter for one multi-cycle multiply/divide (MD) unit launched from E.
- Adds a saturating stall-cycle performance counter. Register-address width and MD latency are parametrised.

Parameters:
- RA_W, 5, register address width; register file has 2**RA_W entries.
- MD_LAT, 4, MD unit latency in cycles from launch to result write, legal range 2..15.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- RsD, RtD  in  RA_W  D-stage source registers
- RegWriteD  in  1  D instruction writes a register
- WriteRegD  in  RA_W  D destination
- BranchD, JumpD, MdOpD  in  1  D is branch / jump / MD op
- RsE, RtE, WriteRegE  in  RA_W  E-stage sources and destination
- RegWriteE, MemtoRegE, MdStartE  in  1  E writes / is load / launches MD
- WriteRegM, WriteRegW  in  RA_W  M and W destinations
- RegWriteM, MemtoRegM, RegWriteW  in  1  M and W control
- ForwardAE, ForwardBE  out  2  10 = from M, 01 = from W, 00 = from register file
- ForwardAD, ForwardBD  out  1  D-stage branch-compare forward from M
- StallF, StallD, FlushE  out  1  pipeline control
- MdBusy  out  1  MD counter nonzero
- MdDone  out  1  MD result written this cycle
- MdDest  out  RA_W  destination of in-flight MD op
- StallCount  out  CNT_W  cycles in which StallD was high

Behaviour:
- Register 0 never causes forwarding, stalls or scoreboard entries.
- Forwarding (combinational):
  - ForwardAE/BE: M match has priority over W.
  - ForwardAD/BD: set on M match with RegWriteM.
- lwstall = MemtoRegE & RtE!=0 & (RsD==RtE | RtD==RtE).
- branchstall = BranchD & [(RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})], with WriteReg!=0.
- MD counter mdcnt (4 bits):
  - Loads MD_LAT on an accepted launch; otherwise decrements while nonzero.
  - MdBusy = mdcnt!=0. MdDone = mdcnt==1 (combinational).
- Launch acceptance:
  - MdStartE is accepted when mdcnt is 0 or 1 and FlushE is 0.
  - A launch while mdcnt>1 is a protocol violation; it is ignored and the counter, scoreboard and MdDest are unchanged.
  - On acceptance MdDest is registered from WriteRegE.
- Scoreboard sb[2**RA_W-1:0]:
  - Accepted launch with WriteRegE!=0 sets sb[WriteRegE].
  - MdDone clears sb[MdDest].
  - Same-cycle set and clear of the same bit: set wins.
  - Bit 0 is always 0.
- mdstall, high when any of:
  - RAW: sb[RsD] or sb[RtD], and not (MdDone & the matching register == MdDest).
  - Structural: MdOpD & mdcnt>1.
  - WAW: RegWriteD & sb[WriteRegD] & !MdDone.
  - E-launch pending: MdStartE & RegWriteE & WriteRegE∈{RsD,RtD}.
- Pipeline control: StallF = StallD = FlushE = lwstall | branchstall | mdstall.
- JumpD never stalls.
- StallCount increments each cycle StallD=1 and saturates at all ones (no wrap).
- Reset (asynchronous, any time including mid-MD-op): mdcnt=0, sb=0, MdDest=0, StallCount=0. All outputs then evaluate to 0.
- Latency:
  - Forwarding and stall outputs are combinational on the current-cycle inputs.
  - Scoreboard and counter effects are visible the cycle after launch.

Test Plan:
- RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. RsE=0 -> 00.
- Load in E with RtE=5, MemtoRegE=1, RsD=5 -> StallF=StallD=FlushE=1 for exactly that cycle; StallCount increments by 1.
- MdStartE, WriteRegE=7, MD_LAT=4; next cycle RsD=7 -> stall for 3 cycles, released in the MdDone cycle; sb[7] is 0 afterwards; MdBusy high for 4 cycles.
- MD in flight with mdcnt=3 and MdOpD=1 -> structural stall. Launch forced at mdcnt=3 -> ignored, MdDest unchanged. Back-to-back launch in the MdDone cycle -> accepted, mdcnt=MD_LAT.
- Pulse rst_n low between clock edges mid-MD-op -> MdBusy, sb, StallCount clear immediately; no stall on the next decode.
- Hold a stall condition for 2**CNT_W+5 cycles (CNT_W=4 build) -> StallCount holds at 15.
